// File: rtl/backbone_pkg.sv
// Shared backbone constants and types; includes the conv1 post-stage additions
// (pooling geometry, requant shift width and the post-stage FSM encoding).
package backbone_pkg;

  localparam int DATA_W     = 8;
  localparam int ACC_W      = 32;

  localparam int CONV1_COUT = 4;
  localparam int CONV1_HW   = 8;
  localparam int POOL_HW    = 4;
  localparam int SHIFT_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } post_state_e;

endpackage

// File: rtl/conv1_requant_unit.sv
// Combinational bias add, ReLU, optional round-half-up, right shift and
// saturation to a non-negative DATA_W_P value. Rounding: CONV1_REQUANT_ROUND_EN.
module conv1_requant_unit
  import backbone_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ACC_W_P  = ACC_W
) (
  input  logic signed [ACC_W_P-1:0]  acc_i,
  input  logic signed [ACC_W_P-1:0]  bias_i,
  input  logic        [SHIFT_W-1:0]  shift_i,
  output logic signed [DATA_W_P-1:0] q_o
);

  // One extra bit for the sum, one more so the rounding add cannot overflow.
  localparam int SW = ACC_W_P + 2;
  localparam logic [SW-1:0] MAX_POS = (SW'(1) << (DATA_W_P - 1)) - SW'(1);

  logic signed [ACC_W_P:0] sum;
  logic [SW-1:0] mag;
  logic [SW-1:0] rounded;
  logic [SW-1:0] shifted;

  assign sum = {acc_i[ACC_W_P-1], acc_i} + {bias_i[ACC_W_P-1], bias_i};

  always_comb begin
    mag     = '0;
    rounded = '0;
    shifted = '0;
    q_o     = '0;
    if (!sum[ACC_W_P]) mag = {1'b0, sum};
`ifdef CONV1_REQUANT_ROUND_EN
    if (shift_i != '0) rounded = mag + (SW'(1) << (shift_i - SHIFT_W'(1)));
    else               rounded = mag;
`else
    rounded = mag;
`endif
    // Value is non-negative here, so a logical shift equals the arithmetic one.
    shifted = rounded >> shift_i;
    if (shifted > MAX_POS) q_o = MAX_POS[DATA_W_P-1:0];
    else                   q_o = shifted[DATA_W_P-1:0];
  end

endmodule

// File: rtl/conv1_relu_pool_requant.sv
// conv1 post-stage: 2x2 max-pool, then bias/ReLU/requant, one pooled element
// per cycle through a 2-stage pipeline. Optional rounding: CONV1_REQUANT_ROUND_EN.
module conv1_relu_pool_requant
  import backbone_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ACC_W_P  = ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic signed [ACC_W_P-1:0]  acc_i  [CONV1_COUT][CONV1_HW][CONV1_HW],
  input  logic signed [ACC_W_P-1:0]  bias_i [CONV1_COUT],
  input  logic        [SHIFT_W-1:0]  shift_i,
  output logic signed [DATA_W_P-1:0] out_o  [CONV1_COUT][POOL_HW][POOL_HW],
  output post_state_e                dbg_state
);

  // Handshake: start is a level sampled on a rising edge; it is taken only when
  // the FSM is IDLE and otherwise dropped. busy covers RUN and DRAIN; done is a
  // single-cycle pulse on the edge that returns to IDLE.

  post_state_e state_q, state_d;
  logic [5:0]                 cnt_q;
  logic signed [ACC_W_P-1:0]  bias_q [CONV1_COUT];
  logic [SHIFT_W-1:0]         shift_q;
  logic                       done_q;

  logic                       v1_q;
  logic signed [ACC_W_P-1:0]  mx_q;
  logic [5:0]                 idx_q;

  logic signed [ACC_W_P-1:0]  win_max;
  logic signed [ACC_W_P-1:0]  w00, w01, w10, w11, m0, m1;
  logic [1:0]                 co;
  logic [2:0]                 r0, r1, c0, c1;
  logic signed [DATA_W_P-1:0] rq;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 6'd63) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      for (int c = 0; c < CONV1_COUT; c++) bias_q[c] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN);
      if (state_q == IDLE && start) begin
        cnt_q   <= '0;
        shift_q <= shift_i;
        for (int c = 0; c < CONV1_COUT; c++) bias_q[c] <= bias_i[c];
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

  // Stage 1: window max. Pooling before requant is exact since requant is monotone.
  always_comb begin
    co  = cnt_q[5:4];
    r0  = {cnt_q[3:2], 1'b0};
    r1  = {cnt_q[3:2], 1'b1};
    c0  = {cnt_q[1:0], 1'b0};
    c1  = {cnt_q[1:0], 1'b1};
    w00 = acc_i[co][r0][c0];
    w01 = acc_i[co][r0][c1];
    w10 = acc_i[co][r1][c0];
    w11 = acc_i[co][r1][c1];
    m0  = (w00 > w01) ? w00 : w01;
    m1  = (w10 > w11) ? w10 : w11;
    win_max = (m0 > m1) ? m0 : m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      mx_q  <= '0;
      idx_q <= '0;
    end else begin
      v1_q <= (state_q == RUN);
      if (state_q == RUN) begin
        mx_q  <= win_max;
        idx_q <= cnt_q;
      end
    end
  end

  conv1_requant_unit #(
    .DATA_W_P (DATA_W_P),
    .ACC_W_P  (ACC_W_P)
  ) u_requant (
    .acc_i   (mx_q),
    .bias_i  (bias_q[idx_q[5:4]]),
    .shift_i (shift_q),
    .q_o     (rq)
  );

  // Stage 2: write the pooled element; untouched elements keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CONV1_COUT; c++)
        for (int h = 0; h < POOL_HW; h++)
          for (int w = 0; w < POOL_HW; w++)
            out_o[c][h][w] <= '0;
    end else if (v1_q) begin
      out_o[idx_q[5:4]][idx_q[3:2]][idx_q[1:0]] <= rq;
    end
  end

endmodule

// File: tb/tb_conv1_relu_pool_requant.sv
// Randomized and directed bench for conv1_relu_pool_requant against a
// per-element requant-then-pool reference model.
module tb_conv1_relu_pool_requant;
  import backbone_pkg::*;

  localparam int DW = DATA_W;
  localparam int AW = ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic signed [AW-1:0] acc [CONV1_COUT][CONV1_HW][CONV1_HW];
  logic signed [AW-1:0] bias [CONV1_COUT];
  logic [SHIFT_W-1:0] shift;
  logic signed [DW-1:0] out [CONV1_COUT][POOL_HW][POOL_HW];
  post_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  conv1_relu_pool_requant #(.DATA_W_P(DW), .ACC_W_P(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .acc_i     (acc),
    .bias_i    (bias),
    .shift_i   (shift),
    .out_o     (out),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: requantize every accumulator on its own, then take the window max
  function automatic longint requant(input longint a, input longint b, input int sh);
    longint s;
    longint mx;
    mx = (longint'(1) << (DW - 1)) - 1;
    s = a + b;
    if (s < 0) s = 0;
`ifdef CONV1_REQUANT_ROUND_EN
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
`endif
    s = s / (longint'(1) << sh);
    if (s > mx) s = mx;
    return s;
  endfunction

  task automatic build_expected();
    longint best, v;
    exp_q.delete();
    for (int c = 0; c < CONV1_COUT; c++)
      for (int h = 0; h < POOL_HW; h++)
        for (int w = 0; w < POOL_HW; w++) begin
          best = -1;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = requant(longint'(acc[c][2*h+dy][2*w+dx]), longint'(bias[c]), int'(shift));
              if (v > best) best = v;
            end
          exp_q.push_back(DW'(best));
        end
  endtask

  task automatic compare_outputs(input string tag);
    logic [DW-1:0] e;
    for (int c = 0; c < CONV1_COUT; c++)
      for (int h = 0; h < POOL_HW; h++)
        for (int w = 0; w < POOL_HW; w++) begin
          e = exp_q.pop_front();
          check($sformatf("%s out[%0d][%0d][%0d]", tag, c, h, w), 64'(out[c][h][w]), {56'd0, e});
        end
  endtask

  // driver tasks
  task automatic fill_const(input int v);
    for (int c = 0; c < CONV1_COUT; c++)
      for (int r = 0; r < CONV1_HW; r++)
        for (int k = 0; k < CONV1_HW; k++)
          acc[c][r][k] = AW'(v);
  endtask

  task automatic fill_range(input int lo, input int hi);
    for (int c = 0; c < CONV1_COUT; c++)
      for (int r = 0; r < CONV1_HW; r++)
        for (int k = 0; k < CONV1_HW; k++)
          acc[c][r][k] = AW'(lo + int'($urandom_range(hi - lo)));
  endtask

  task automatic fill_full();
    for (int c = 0; c < CONV1_COUT; c++)
      for (int r = 0; r < CONV1_HW; r++)
        for (int k = 0; k < CONV1_HW; k++)
          acc[c][r][k] = AW'($urandom());
  endtask

  task automatic set_bias(input int b);
    for (int c = 0; c < CONV1_COUT; c++) bias[c] = AW'(b);
  endtask

  // Runs one job, checks handshake timing, then the whole output map.
  task automatic run_job(input string tag, input bit glitch);
    int done_at;
    int busy_bad;
    build_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " busy_e0"}, 64'(busy), 64'd1);
    done_at = 0;
    busy_bad = 0;
    for (int n = 1; n <= 100 && done_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (done) done_at = n;
      else if (!busy) busy_bad++;
      start = glitch && (n == 19 || n == 64) && (done_at == 0);
    end
    start = 1'b0;
    check({tag, " done_edge"}, 64'(done_at), 64'd65);
    check({tag, " busy_hold"}, 64'(busy_bad), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, " done_fall"}, 64'(done), 64'd0);
    check({tag, " idle_after"}, 64'(busy), 64'd0);
    compare_outputs(tag);
  endtask

  initial begin
    int done_seen;
    shift = '0;
    fill_const(0);
    set_bias(0);
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out", 64'(out[3][3][3]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fill_const(100); set_bias(0); shift = 5'd2;
    run_job("t1", 1'b1);
    check("t1 const", 64'(out[2][1][3]), 64'd25);

    fill_const(-50); set_bias(10); shift = 5'd0;
    run_job("t2", 1'b0);
    check("t2 const", 64'(out[0][0][0]), 64'd0);

    fill_const(100000); set_bias(0); shift = 5'd0;
    run_job("t3", 1'b0);
    check("t3 const", 64'(out[1][2][0]), 64'd127);

    fill_const(0); set_bias(0); shift = 5'd0;
    acc[0][0][0] = 3; acc[0][0][1] = 9; acc[0][1][0] = -4; acc[0][1][1] = 7;
    acc[1][2][2] = -5; acc[1][2][3] = -5; acc[1][3][2] = -5; acc[1][3][3] = -5;
    run_job("t4", 1'b0);
    check("t4 w000", 64'(out[0][0][0]), 64'd9);
    check("t4 w111", 64'(out[1][1][1]), 64'd0);

    fill_const(6); set_bias(0); shift = 5'd2;
    run_job("t5", 1'b0);
`ifdef CONV1_REQUANT_ROUND_EN
    check("t5 const", 64'(out[3][0][2]), 64'd2);
`else
    check("t5 const", 64'(out[3][0][2]), 64'd1);
`endif

    // reset mid-run with an ignored second start
    fill_range(-300, 3000); set_bias(20); shift = 5'd3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      start = (n == 9);
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6 busy_rst", 64'(busy), 64'd0);
    check("t6 done_rst", 64'(done), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back('0);
    compare_outputs("t6 cleared");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("t6 no_done", 64'(done_seen), 64'd0);
    run_job("t6 fresh", 1'b0);

    // randomized runs, including full-range sums that exceed ACC_W
    for (int i = 0; i < 4; i++) begin
      fill_range(-5000, 40000);
      for (int c = 0; c < CONV1_COUT; c++) bias[c] = AW'(int'($urandom_range(4000)) - 2000);
      shift = SHIFT_W'($urandom_range(8));
      run_job($sformatf("rnd%0d", i), 1'b1);
    end
    fill_full();
    for (int c = 0; c < CONV1_COUT; c++) bias[c] = AW'($urandom());
    shift = SHIFT_W'($urandom_range(31));
    run_job("full", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
